// File: rtl/matrix_mem_scheduler_if.sv
// Bus between the matrix memory clients, the memory macro and the burst scheduler.
//
// Handshake: a client raises req[i] with stable req_we/req_base/req_len and keeps it
// high until it sees done[i]. It drops req on the cycle after done. Write beats
// are consumed when wr_pop[i] is high. The client must then present its next word
// on the following cycle. Read beats are delivered when rd_valid[i] is high. There
// is no back-pressure on read data, so every read beat must be accepted.
interface matrix_mem_scheduler_if #(
    parameter int NREQ = 3,
    parameter int AW   = 7,
    parameter int DW   = 16,
    parameter int LENW = 5
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*AW-1:0]   req_base;
    logic [NREQ*LENW-1:0] req_len;
    logic [NREQ*DW-1:0]   wr_data;
    logic [DW-1:0]        mem_q;
    logic [AW-1:0]        mem_addr;
    logic                 mem_we;
    logic [DW-1:0]        mem_wdata;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      wr_pop;
    logic [DW-1:0]        rd_data;
    logic [NREQ-1:0]      rd_valid;
    logic [NREQ-1:0]      done;
    logic                 busy;

    // Coprocessor side: the memory clients together with the memory macro.
    modport master (
        output req, req_we, req_base, req_len, wr_data, mem_q,
        input  mem_addr, mem_we, mem_wdata, grant, wr_pop, rd_data, rd_valid, done, busy
    );

    // Scheduler side: the single owner of the memory port.
    modport slave (
        input  req, req_we, req_base, req_len, wr_data, mem_q,
        output mem_addr, mem_we, mem_wdata, grant, wr_pop, rd_data, rd_valid, done, busy
    );
endinterface

// File: rtl/matrix_mem_scheduler.sv
// Round-robin burst scheduler that owns the single-port matrix memory.
// One client at a time is granted a burst. The scheduler then issues one address per cycle,
// drives the write enable and data mux, and tags returning read data with a per-client valid.
module matrix_mem_scheduler #(
    parameter int NREQ   = 3,
    parameter int AW     = 7,
    parameter int DW     = 16,
    parameter int LENW   = 5,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    matrix_mem_scheduler_if.slave bus,
    output logic [1:0]           dbg_state_o
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [LENW-1:0] len_q, len_d;
    logic [LENW-1:0] cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            mem_we_q, mem_we_d;

    // Read-valid shift register; stage RD_LAT-1 lines up with mem_q.
    logic [NREQ-1:0] rd_pipe_q [RD_LAT];
    logic [NREQ-1:0] rd_issue;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] owner_oh;
    logic            last_beat;
    logic            drain_end;

    logic [NREQ-1:0] grant_c;
    logic [NREQ-1:0] done_c;
    logic            busy_c;
    logic [DW-1:0]   wdata_c;

    // Client index probed at search offset off, starting one past the last owner.
    function automatic logic [IW-1:0] rr_slot(input logic [IW-1:0] last, input int off);
        int t;
        t = int'(last) + 1 + off;
        if (t >= NREQ) t = t - NREQ;
        if (t >= NREQ) t = t - NREQ;
        return IW'(t);
    endfunction

    assign owner_oh  = NREQ'(1) << owner_q;
    assign last_beat = (cnt_q == len_q);
    assign drain_end = (cnt_q == LENW'(RD_LAT - 1));

    // Round-robin pick: the first requester found after the last owner wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && bus.req[rr_slot(last_q, i)]) begin
                win_found = 1'b1;
                win_idx   = rr_slot(last_q, i);
            end
        end
    end

    // State register; reset parks the FSM in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: reads drain the return pipeline before DONE, writes skip it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (win_found) state_d = S_XFER;
            S_XFER:  if (last_beat) state_d = we_q ? S_DONE : S_DRAIN;
            S_DRAIN: if (drain_end) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Burst datapath next-state: latch the winner's burst, then step address and beat count.
    always_comb begin
        owner_d    = owner_q;
        last_d     = last_q;
        len_d      = len_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        mem_we_d   = mem_we_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    owner_d    = win_idx;
                    len_d      = bus.req_len[win_idx*LENW +: LENW];
                    we_d       = bus.req_we[win_idx];
                    cnt_d      = '0;
                    mem_addr_d = bus.req_base[win_idx*AW +: AW];
                    mem_we_d   = bus.req_we[win_idx];
                end
            end
            S_XFER: begin
                if (last_beat) begin
                    // The counter is reused to time the read drain.
                    cnt_d    = '0;
                    mem_we_d = 1'b0;
                end else begin
                    // Address wraps naturally at 2^AW.
                    cnt_d      = cnt_q + LENW'(1);
                    mem_addr_d = mem_addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + LENW'(1);
            end
            S_DONE: begin
                last_d = owner_q;
            end
            default: begin
            end
        endcase
    end

    // Burst datapath registers; after reset client 0 has the highest priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= '0;
            last_q     <= IW'(NREQ - 1);
            len_q      <= '0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            last_q     <= last_d;
            len_q      <= len_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
        end
    end

    // A read beat is issued on every XFER cycle of a read burst.
    assign rd_issue = (state_q == S_XFER && !we_q) ? owner_oh : '0;

    // Read-valid pipeline; reset discards any beats still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) rd_pipe_q[i] <= '0;
        end else begin
            rd_pipe_q[0] <= rd_issue;
            for (int i = 1; i < RD_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
        end
    end

    // Output decode from state: the grant spans XFER and DRAIN, and done marks the DONE cycle.
    always_comb begin
        grant_c = '0;
        done_c  = '0;
        busy_c  = (state_q != S_IDLE);
        case (state_q)
            S_XFER, S_DRAIN: grant_c = owner_oh;
            S_DONE:          done_c  = owner_oh;
            default: begin
            end
        endcase
    end

    // Write data mux on the current grant; zero when nobody owns the port.
    always_comb begin
        wdata_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_c[i]) wdata_c = bus.wr_data[i*DW +: DW];
        end
    end

    assign bus.grant     = grant_c;
    assign bus.done      = done_c;
    assign bus.busy      = busy_c;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = wdata_c;
    assign bus.wr_pop    = grant_c & {NREQ{mem_we_q}};
    assign bus.rd_data   = bus.mem_q;
    assign bus.rd_valid  = rd_pipe_q[RD_LAT-1];
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_matrix_mem_scheduler.sv
module tb_matrix_mem_scheduler;
  localparam int NREQ = 3;
  localparam int AW = 7;
  localparam int DW = 16;
  localparam int LENW = 5;
  localparam int RD_LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg_state;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_mem_scheduler_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .LENW(LENW)) bus ();

  matrix_mem_scheduler #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .LENW(LENW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- memory: 128x16, RD_LAT cycles from address to q ----------------
  logic [DW-1:0] mem [128];
  logic [DW-1:0] mq [RD_LAT];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    mq[0] <= mem[bus.mem_addr];
    for (int i = 1; i < RD_LAT; i++) mq[i] <= mq[i-1];
  end
  assign bus.mem_q = mq[RD_LAT-1];

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  typedef struct {
    string name;
    logic [31:0] act;
    logic [31:0] exp;
  } lit_t;
  lit_t lit_q[$];
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Literal expectations are queued and checked by the compare process.
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    lit_t l;
    l.name = name;
    l.act = act;
    l.exp = exp;
    lit_q.push_back(l);
  endtask

  // ---------------- behavioural model (burst timeline) ----------------
  // A burst accepted when cyc==m_start has beat k at t=k+1, where t=cyc-m_start.
  // Read data returns at t=k+1+RD_LAT. done is one cycle after the last beat or return.
  logic m_active = 1'b0;
  int m_owner = 0;
  int m_last = NREQ - 1;
  int m_start = 0;
  logic [AW-1:0] m_base = '0;
  int m_len = 0;
  logic m_we = 1'b0;
  logic [DW-1:0] shadow [128];
  logic [NREQ-1:0] seen_pop = '0;
  logic [NREQ-1:0] seen_done = '0;

  int mt, m_end, pick;
  logic in_burst, beat;
  logic [NREQ-1:0] e_oh, e_grant, e_done, e_rdv, e_pop;
  logic [AW-1:0] e_addr;
  lit_t cur;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_wr_pop", 32'(bus.wr_pop), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      m_active = 1'b0;
      m_last = NREQ - 1;
    end else begin
      mt = cyc - m_start;
      in_burst = m_active && (mt >= 1);
      m_end = m_len + 1 + (m_we ? 0 : RD_LAT);
      beat = in_burst && (mt <= m_len + 1);
      e_oh = NREQ'(1) << m_owner;
      e_grant = (in_burst && mt <= m_end) ? e_oh : '0;
      e_done = (m_active && mt == m_end + 1) ? e_oh : '0;
      e_pop = (beat && m_we) ? e_oh : '0;
      e_rdv = (in_burst && !m_we && mt >= 1 + RD_LAT && mt <= m_len + 1 + RD_LAT) ? e_oh : '0;
      e_addr = AW'(int'(m_base) + mt - 1);
      chk("grant", 32'(bus.grant), 32'(e_grant));
      chk("busy", 32'(bus.busy), 32'(in_burst && mt <= m_end + 1));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("wr_pop", 32'(bus.wr_pop), 32'(e_pop));
      chk("mem_we", 32'(bus.mem_we), 32'(beat && m_we));
      chk("rd_valid", 32'(bus.rd_valid), 32'(e_rdv));
      chk("mem_wdata", 32'(bus.mem_wdata),
          (e_grant != 0) ? 32'(bus.wr_data[m_owner*DW +: DW]) : 32'd0);
      if (beat) chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
      if (e_rdv != 0)
        chk("rd_data", 32'(bus.rd_data), 32'(shadow[AW'(int'(m_base) + mt - 1 - RD_LAT)]));
      if (beat && m_we) shadow[e_addr] = bus.wr_data[m_owner*DW +: DW];
      if (m_active) begin
        if (mt == m_end + 1) begin
          m_active = 1'b0;
          m_last = m_owner;
        end
      end else if (bus.req != 0) begin
        pick = -1;
        for (int k = 1; k <= NREQ; k++) begin
          if (pick < 0 && bus.req[(m_last + k) % NREQ]) pick = (m_last + k) % NREQ;
        end
        m_active = 1'b1;
        m_owner = pick;
        m_start = cyc;
        m_base = bus.req_base[pick*AW +: AW];
        m_len = int'(bus.req_len[pick*LENW +: LENW]);
        m_we = bus.req_we[pick];
      end
    end
    while (lit_q.size() > 0) begin
      cur = lit_q.pop_front();
      chk(cur.name, cur.act, cur.exp);
    end
    seen_pop = bus.wr_pop;
    seen_done = bus.done;
  end

  // ---------------- driver tasks ----------------
  logic [DW-1:0] wd_off [NREQ];
  int wptr [NREQ];
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] got_q[$];

  // Advance one cycle; clients step their write word on a pop and drop req after done.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (seen_pop[i]) wptr[i]++;
      if (seen_done[i]) bus.req[i] = 1'b0;
      bus.wr_data[i*DW +: DW] = wd_off[i] + DW'(wptr[i]);
    end
  endtask

  task automatic start_req(input int i, input logic we, input logic [AW-1:0] base,
                           input logic [LENW-1:0] len, input logic [DW-1:0] off);
    bus.req_we[i] = we;
    bus.req_base[i*AW +: AW] = base;
    bus.req_len[i*LENW +: LENW] = len;
    wd_off[i] = off;
    wptr[i] = 0;
    bus.wr_data[i*DW +: DW] = off;
    bus.req[i] = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) lit("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  // Run client i's burst to done; optionally disturb its inputs at cycle chg_at.
  task automatic run_burst(input int i, input int chg_at, output int done_t,
                           output int pops, output int we_cnt);
    int t = 0;
    done_t = -1;
    pops = 0;
    we_cnt = 0;
    addr_q.delete();
    got_q.delete();
    while (done_t < 0 && t < 120) begin
      tick();
      t++;
      if (t == chg_at) begin
        bus.req[i] = 1'b0;
        bus.req_base[i*AW +: AW] = 7'd100;
        bus.req_we[i] = ~bus.req_we[i];
        bus.req_len[i*LENW +: LENW] = 5'd1;
      end
      if (bus.wr_pop[i]) begin
        pops++;
        addr_q.push_back(bus.mem_addr);
      end
      if (bus.grant[i] && bus.mem_we) we_cnt++;
      if (bus.rd_valid[i]) got_q.push_back(bus.rd_data);
      if (bus.done[i]) done_t = t;
    end
    if (done_t < 0) lit("burst_timeout", 32'd1, 32'd0);
  endtask

  // ---------------- directed stimulus ----------------
  int dt, np, nw, n;
  int order[$];
  logic [NREQ-1:0] prev_g;
  logic re0;
  logic [AW-1:0] wrap_exp [4];

  initial begin
    for (int a = 0; a < 128; a++) shadow[a] = '0;
    for (int i = 0; i < NREQ; i++) begin
      wd_off[i] = '0;
      wptr[i] = 0;
    end
    rst = 1'b1;
    bus.req = '0;
    bus.req_we = '0;
    bus.req_base = '0;
    bus.req_len = '0;
    bus.wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    lit("post_rst_busy", 32'(bus.busy), 32'd0);
    lit("post_rst_grant", 32'(bus.grant), 32'd0);
    lit("post_rst_state", 32'(dbg_state), 32'd0);

    // Contention straight after reset: order 0,1,2, then re-requesting 0 comes after 2.
    for (int i = 0; i < NREQ; i++) start_req(i, 1'b1, AW'(100 + i), 5'd0, DW'(16'h0100 * (i + 1)));
    prev_g = '0;
    re0 = 1'b0;
    n = 0;
    while (!(order.size() == 4 && bus.busy == 1'b0) && n < 80) begin
      tick();
      n++;
      if (bus.grant != 0 && prev_g == 0) begin
        for (int i = 0; i < NREQ; i++) if (bus.grant[i]) order.push_back(i);
        if (bus.grant[1] && !re0) begin
          start_req(0, 1'b1, 7'd103, 5'd0, 16'h0900);
          re0 = 1'b1;
        end
      end
      prev_g = bus.grant;
    end
    lit("rr_count", 32'(order.size()), 32'd4);
    if (order.size() == 4) begin
      lit("rr_first", 32'(order[0]), 32'd0);
      lit("rr_second", 32'(order[1]), 32'd1);
      lit("rr_third", 32'(order[2]), 32'd2);
      lit("rr_fourth", 32'(order[3]), 32'd0);
    end

    // Single 25-word write from client 0, data = index.
    wait_idle();
    start_req(0, 1'b1, 7'd0, 5'd24, 16'h0000);
    run_burst(0, -1, dt, np, nw);
    lit("wr25_pops", 32'(np), 32'd25);
    lit("wr25_done_cycle", 32'(dt), 32'd26);
    for (int k = 0; k < addr_q.size(); k++) lit("wr25_addr", 32'(addr_q[k]), 32'(k));

    // 25-word read from client 1 returns the words just written.
    wait_idle();
    start_req(1, 1'b0, 7'd0, 5'd24, 16'h0000);
    run_burst(1, -1, dt, np, nw);
    for (int k = 0; k < 25; k++) exp_q.push_back(DW'(k));
    lit("rd25_count", 32'(got_q.size()), 32'd25);
    for (int k = 0; k < got_q.size() && exp_q.size() > 0; k++)
      lit("rd25_data", 32'(got_q[k]), 32'(exp_q.pop_front()));
    exp_q.delete();
    lit("rd25_done_cycle", 32'(dt), 32'd28);
    lit("rd25_no_we", 32'(nw), 32'd0);

    // Wrap: base 126, four words.
    wait_idle();
    start_req(2, 1'b1, 7'd126, 5'd3, 16'h2000);
    run_burst(2, -1, dt, np, nw);
    wrap_exp[0] = 7'd126;
    wrap_exp[1] = 7'd127;
    wrap_exp[2] = 7'd0;
    wrap_exp[3] = 7'd1;
    lit("wrap_pops", 32'(np), 32'd4);
    lit("wrap_done_cycle", 32'(dt), 32'd5);
    for (int k = 0; k < 4 && k < addr_q.size(); k++) lit("wrap_addr", 32'(addr_q[k]), 32'(wrap_exp[k]));

    // Read the wrapped words back through client 0.
    wait_idle();
    start_req(0, 1'b0, 7'd126, 5'd3, 16'h0000);
    run_burst(0, -1, dt, np, nw);
    lit("wrap_rd_count", 32'(got_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < got_q.size(); k++) lit("wrap_rd_data", 32'(got_q[k]), 32'(16'h2000 + k));
    lit("wrap_rd_done_cycle", 32'(dt), 32'd7);

    // Single-word write.
    wait_idle();
    start_req(2, 1'b1, 7'd60, 5'd0, 16'h3000);
    run_burst(2, -1, dt, np, nw);
    lit("single_pops", 32'(np), 32'd1);
    lit("single_done_cycle", 32'(dt), 32'd2);
    if (addr_q.size() > 0) lit("single_addr", 32'(addr_q[0]), 32'd60);

    // Owner drops req and changes base/we/len mid-burst: original burst runs to completion.
    wait_idle();
    start_req(2, 1'b1, 7'd40, 5'd7, 16'h4000);
    run_burst(2, 3, dt, np, nw);
    lit("chg_pops", 32'(np), 32'd8);
    lit("chg_done_cycle", 32'(dt), 32'd9);
    for (int k = 0; k < addr_q.size(); k++) lit("chg_addr", 32'(addr_q[k]), 32'(40 + k));

    // Reset during beat 10 of a 25-beat read.
    wait_idle();
    start_req(1, 1'b0, 7'd0, 5'd24, 16'h0000);
    repeat (11) tick();
    lit("pre_rst_addr", 32'(bus.mem_addr), 32'd10);
    rst = 1'b1;
    #1;
    lit("async_grant", 32'(bus.grant), 32'd0);
    lit("async_busy", 32'(bus.busy), 32'd0);
    lit("async_mem_addr", 32'(bus.mem_addr), 32'd0);
    lit("async_rd_valid", 32'(bus.rd_valid), 32'd0);
    lit("async_state", 32'(dbg_state), 32'd0);
    start_req(0, 1'b1, 7'd70, 5'd0, 16'h5000);
    start_req(1, 1'b1, 7'd71, 5'd0, 16'h6000);
    start_req(2, 1'b1, 7'd72, 5'd0, 16'h7000);
    repeat (2) tick();
    rst = 1'b0;
    n = 0;
    while (bus.grant == 0 && n < 10) begin
      tick();
      n++;
    end
    lit("rst_first_grant", 32'(bus.grant), 32'd1);
    n = 0;
    while ((bus.req != 0 || bus.busy) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) lit("drain_timeout", 32'd1, 32'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/matrix_mem_scheduler.md
# matrix_mem_scheduler

Round-robin burst scheduler that shares the single-port 128x16 matrix memory between the coprocessor's memory clients: the operand loader, the operand fetch for the ALU, and the result writer. Each client requests a burst with a base address, length and direction. The scheduler grants one client at a time, generates the memory address, write-enable and data sequence itself, and returns read data with per-client valid strobes. It replaces the ad-hoc address/wren sequencing in the coprocessor FSM with a single owner of the memory port.

## Interface
- NREQ, 3, number of requesters (0 = loader, 1 = operand fetch, 2 = result writer)
- AW, 7, memory address width
- DW, 16, memory data width
- LENW, 5, burst length field width; a burst is len+1 words (1..32)
- RD_LAT, 1, memory read latency in cycles (address to valid q), legal 1..3

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-client burst request; held high until that client's done
- req_we  in  NREQ  per-client direction: 1 = write burst, 0 = read burst
- req_base  in  NREQ*AW  per-client start address; client i uses bits [i*AW +: AW]
- req_len  in  NREQ*LENW  per-client burst length minus one
- wr_data  in  NREQ*DW  per-client write word for the current beat
- mem_q  in  DW  memory read data
- mem_addr  out  AW  memory address (registered)
- mem_we  out  1  memory write enable (registered)
- mem_wdata  out  DW  wr_data of the granted client (combinational mux on grant)
- grant  out  NREQ  one-hot owner of the memory port; all-zero when idle
- wr_pop  out  NREQ  one-hot; the granted client's wr_data is written this cycle, and the client advances to its next word
- rd_data  out  DW  equals mem_q
- rd_valid  out  NREQ  one-hot; rd_data is valid for that client this cycle
- done  out  NREQ  one-cycle pulse at burst completion
- busy  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, XFER, DRAIN, DONE.
- IDLE:
  - If any req bit is high, pick the winner round-robin: search starts at last_grant+1 modulo NREQ.
  - Latch the winner's base, len and we. Go to XFER.
  - At the same edge, assert grant and load mem_addr=base and mem_we=we.
- XFER:
  - The beat counter k runs 0..len. Each cycle issues mem_addr=base+k modulo 2^AW.
  - mem_we equals the latched we. wr_pop for the owner equals mem_we.
  - After beat len: a write burst goes to DONE; a read burst goes to DRAIN. mem_we clears at that edge.
- DRAIN: wait until the last read beat returns (RD_LAT cycles after beat len was issued), then go to DONE.
- Read return: the read-valid pipeline is RD_LAT deep, so rd_valid for beat k fires exactly RD_LAT cycles after beat k was issued.
- DONE:
  - grant is all-zero. done for the owner pulses for one cycle.
  - last_grant is updated to the owner. Next state is IDLE.
- The req bit is sampled only in IDLE. A client dropping req mid-burst does not shorten the burst. A client that changes base, len or we mid-burst has no effect on the current burst.
- A client must drop req on the cycle done is seen. If req is still high in the following IDLE cycle, the client is re-arbitrated normally.
- Address wrap: base+k wraps at 2^AW with no error. For example, base 126 with len 3 gives addresses 126, 127, 0, 1.
- Reset (asynchronous, any state):
  - state goes to IDLE; last_grant goes to NREQ-1, so client 0 has the highest priority after reset.
  - grant, wr_pop, rd_valid, done, mem_we, mem_addr and busy go to 0.
  - In-flight read beats are discarded; no rd_valid is issued after reset.
- Reset values of all outputs: 0. mem_wdata is 0 because grant is 0. rd_data follows mem_q.

## Timing
- Request to first beat: a request seen in IDLE at edge E0 gives grant, mem_addr=base and mem_we at edge E0. The first beat occupies the cycle following E0.
- Write burst: beats occupy cycles 1..len+1 after the request edge; done pulses at cycle len+2.
- Read burst: rd_valid for beat k occurs at cycle k+1+RD_LAT; done pulses at cycle len+2+RD_LAT.
- Turnaround: the DONE and IDLE cycles separate any two bursts. The minimum gap between the last beat of one burst and the first beat of the next is 2 cycles for writes, or RD_LAT+2 cycles for reads.
- Throughput: one word per cycle within a burst; no bubbles.
- Simultaneous requests: exactly one grant; the others wait with no loss. A waiting client is granted within NREQ-1 bursts (no starvation).
- Read data must not be stalled: rd_valid carries no back-pressure, and the client must accept every beat.

## Test plan
- Single write (RD_LAT=1): client 0 requests we=1, base=0, len=24, wr_data=index -> 25 wr_pop pulses on consecutive cycles; mem_addr 0..24; done[0] one cycle after the last beat; memory words 0..24 read back as 0..24.
- Read burst (RD_LAT=2): client 1 requests we=0, base=0, len=24 -> 25 rd_valid[1] pulses; beat k arrives 2 cycles after its address; done[1] at cycle 27+... i.e. cycle len+2+RD_LAT = 28 after the request; mem_we stays 0 throughout.
- Contention: all three clients raise req in the same cycle, each with len=0, immediately after reset -> grants in order 0,1,2. Client 0 then re-requests while 1 and 2 are pending -> the order after 0 remains 1, then 2, before 0 again.
- Wrap and single word: client 2 requests we=1, base=126, len=3 -> mem_addr sequence 126, 127, 0, 1. A separate request with len=0 -> exactly one beat, one wr_pop, one done.
- Reset mid-burst: assert rst during beat 10 of a 25-beat read -> all outputs 0 asynchronously and no further rd_valid. After release, with all three req high, client 0 is granted first.
- Mid-burst input change: the owner drops req and changes req_base during XFER -> the burst completes at the original addresses, with done asserted at the nominal cycle.
